// File: rtl/if_fetch_stage.sv
// IF stage: PC register, single-outstanding instruction fetch FSM and IF/ID pipeline register.
// Redirects from ID take priority over load-use stalls and over loading a fetched word.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_HOLD  = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] hold_buf_q, hold_buf_d;
    logic        hold_valid_q, hold_valid_d;
    logic        kill_q, kill_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;
    logic [31:0] pc_plus4;

    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        hold_buf_d   = hold_buf_q;
        hold_valid_d = hold_valid_q;
        kill_d       = kill_q;
        instr_d      = instr_q;
        pc4_d        = pc4_q;
        valid_d      = valid_q;

        unique case (state_q)
            S_IDLE: begin
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                // The request for the old pc is already on the bus; a redirect marks it stale.
                state_d = S_WAIT;
                if (redirect_valid) kill_d = 1'b1;
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    if (kill_q || redirect_valid) begin
                        kill_d  = 1'b0;
                        state_d = S_ISSUE;
                    end else if (!stall) begin
                        instr_d = imem_rdata;
                        pc4_d   = pc_plus4;
                        valid_d = 1'b1;
                        pc_d    = pc_plus4;
                        state_d = S_ISSUE;
                    end else begin
                        hold_buf_d   = imem_rdata;
                        hold_valid_d = 1'b1;
                        state_d      = S_HOLD;
                    end
                end else if (redirect_valid) begin
                    kill_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    hold_valid_d = 1'b0;
                    state_d      = S_ISSUE;
                end else if (!stall && hold_valid_q) begin
                    instr_d      = hold_buf_q;
                    pc4_d        = pc_plus4;
                    valid_d      = 1'b1;
                    pc_d         = pc_plus4;
                    hold_valid_d = 1'b0;
                    state_d      = S_ISSUE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Redirect overrides whatever the FSM decided for pc and IF/ID.
        if (redirect_valid) begin
            pc_d    = {redirect_pc[31:2], 2'b00};
            instr_d = NOP_INSTR;
            pc4_d   = 32'd0;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            hold_buf_q   <= 32'd0;
            hold_valid_q <= 1'b0;
            kill_q       <= 1'b0;
            instr_q      <= NOP_INSTR;
            pc4_q        <= 32'd0;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            hold_buf_q   <= hold_buf_d;
            hold_valid_q <= hold_valid_d;
            kill_q       <= kill_d;
            instr_q      <= instr_d;
            pc4_q        <= pc4_d;
            valid_q      <= valid_d;
        end
    end

    assign imem_req       = (state_q == S_ISSUE);
    assign imem_addr      = pc_q;
    assign if_id_instr    = instr_q;
    assign if_id_pc_plus4 = pc4_q;
    assign if_id_valid    = valid_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios plus randomized stall/redirect/latency traffic
// checked every cycle against a transaction-level model of the fetch unit.
module tb_if_fetch_stage;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_valid;

    always #5 clk = ~clk;

    if_fetch_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .if_id_instr    (if_id_instr),
        .if_id_pc_plus4 (if_id_pc_plus4),
        .if_id_valid    (if_id_valid)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    // Transaction-level model: a fetch is "due", "in flight" (maybe stale) or "parked" behind a stall.
    bit          m_boot, m_due, m_flight, m_stale, m_parked;
    logic [31:0] m_pc, m_parked_word, m_instr, m_pc4;
    bit          m_valid;

    // Memory responder state
    bit          pend;
    int          cnt;
    logic [31:0] mem_a;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic deliver(input logic [31:0] w);
        m_instr = w;
        m_pc4   = m_pc + 32'd4;
        m_valid = 1'b1;
    endtask

    task automatic model_edge();
        logic [31:0] next_pc;
        next_pc = m_pc;
        if (!reset) begin
            m_pc = RESET_PC; m_boot = 1; m_due = 0; m_flight = 0; m_stale = 0; m_parked = 0;
            m_instr = NOP; m_pc4 = 32'd0; m_valid = 0;
            return;
        end
        if (m_boot) begin
            m_boot = 0; m_due = 1;
        end else if (m_due) begin
            m_due = 0; m_flight = 1; m_stale = redirect_valid;
        end else if (m_flight) begin
            if (imem_rvalid) begin
                m_flight = 0; m_due = 1;
                if (m_stale || redirect_valid) m_stale = 0;
                else if (!stall) begin deliver(imem_rdata); next_pc = m_pc + 32'd4; end
                else begin m_parked = 1; m_parked_word = imem_rdata; m_due = 0; end
            end else if (redirect_valid) m_stale = 1;
        end else if (m_parked) begin
            if (redirect_valid) begin m_parked = 0; m_due = 1; end
            else if (!stall) begin
                deliver(m_parked_word); next_pc = m_pc + 32'd4; m_parked = 0; m_due = 1;
            end
        end
        if (redirect_valid) begin
            m_instr = NOP; m_pc4 = 32'd0; m_valid = 0;
            next_pc = {redirect_pc[31:2], 2'b00};
        end
        m_pc = next_pc;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("imem_req", 32'(imem_req), 32'(m_due));
        if (m_due) chk("imem_addr", imem_addr, m_pc);
        chk("if_id_instr", if_id_instr, m_instr);
        chk("if_id_pc_plus4", if_id_pc_plus4, m_pc4);
        chk("if_id_valid", 32'(if_id_valid), 32'(m_valid));
    endtask

    task automatic drive(input bit st, input bit rv, input logic [31:0] rd,
                         input bit rdv, input logic [31:0] rpc);
        stall = st; imem_rvalid = rv; imem_rdata = rd;
        redirect_valid = rdv; redirect_pc = rpc;
        tick();
    endtask

    task automatic mem_drive();
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        if (pend) begin
            if (cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = 32'h1111_0000 + mem_a;
                pend        = 0;
            end else cnt--;
        end
    endtask

    task automatic run(input int n, input int maxlat, input bit rnd);
        for (int i = 0; i < n; i++) begin
            stall = 0; redirect_valid = 0; reset = 1;
            if (rnd) begin
                stall          = ($urandom_range(0, 3) == 0);
                redirect_valid = ($urandom_range(0, 9) == 0);
                redirect_pc    = $urandom;
                reset          = ($urandom_range(0, 39) != 0);
            end
            if (!reset) pend = 0;
            else if (m_due && !pend) begin
                pend = 1; mem_a = m_pc; cnt = $urandom_range(1, maxlat);
            end
            mem_drive();
            tick();
        end
        reset = 1;
    endtask

    task automatic to_issue();
        stall = 0; redirect_valid = 0; reset = 1;
        if (m_due) pend = 0;
        for (int k = 0; k < 20; k++) begin
            if (m_due) return;
            mem_drive();
            tick();
        end
        chk("to_issue_timeout", 32'(imem_req), 32'd1);
    endtask

    logic [31:0] a;

    initial begin
        pend = 0; cnt = 0; mem_a = 0;

        // T1: reset two cycles, first request right after release
        reset = 0;
        tick(); tick();
        reset = 1;
        tick();
        chk("T1_req", 32'(imem_req), 32'd1);
        chk("T1_addr", imem_addr, RESET_PC);
        chk("T1_valid", 32'(if_id_valid), 32'd0);

        // T2: latency-1 memory, no stall
        run(8, 1, 0);
        chk("T2_pc4", if_id_pc_plus4, 32'd16);
        chk("T2_instr", if_id_instr, 32'h1111_000C);

        // T3: stall raised on the response cycle, held three cycles
        to_issue();
        a = m_pc;
        drive(0, 0, 32'd0, 0, 32'd0);
        drive(1, 1, 32'hCAFE_0001, 0, 32'd0);
        drive(1, 0, 32'd0, 0, 32'd0);
        drive(1, 0, 32'd0, 0, 32'd0);
        drive(0, 0, 32'd0, 0, 32'd0);
        chk("T3_instr", if_id_instr, 32'hCAFE_0001);
        chk("T3_pc4", if_id_pc_plus4, a + 32'd4);
        chk("T3_next_addr", imem_addr, a + 32'd4);

        // T4: redirect during WAIT, stale response one cycle later
        to_issue();
        drive(0, 0, 32'd0, 0, 32'd0);
        drive(0, 0, 32'd0, 1, 32'h0000_0040);
        drive(0, 1, 32'hDEAD_0004, 0, 32'd0);
        chk("T4_addr", imem_addr, 32'h0000_0040);
        chk("T4_valid", 32'(if_id_valid), 32'd0);

        // T5: redirect, response and stall in the same cycle
        to_issue();
        drive(0, 0, 32'd0, 0, 32'd0);
        drive(1, 1, 32'hDEAD_0005, 1, 32'h0000_0083);
        chk("T5_addr", imem_addr, 32'h0000_0080);
        chk("T5_instr", if_id_instr, NOP);
        chk("T5_pc4", if_id_pc_plus4, 32'd0);

        // T6: reset while waiting; responses during reset and in IDLE are dropped
        to_issue();
        drive(0, 0, 32'd0, 0, 32'd0);
        reset = 0;
        drive(0, 1, 32'hDEAD_0006, 0, 32'd0);
        drive(0, 0, 32'd0, 0, 32'd0);
        reset = 1;
        drive(0, 1, 32'hDEAD_0007, 0, 32'd0);
        chk("T6_addr", imem_addr, RESET_PC);
        chk("T6_valid", 32'(if_id_valid), 32'd0);

        // T7: pc wraps from 0xFFFF_FFFC to 0
        to_issue();
        drive(0, 0, 32'd0, 1, 32'hFFFF_FFFF);
        drive(0, 1, 32'hDEAD_0008, 0, 32'd0);
        chk("T7_addr", imem_addr, 32'hFFFF_FFFC);
        drive(0, 0, 32'd0, 0, 32'd0);
        drive(0, 1, 32'h1234_5678, 0, 32'd0);
        chk("T7_pc4", if_id_pc_plus4, 32'd0);
        chk("T7_next_addr", imem_addr, 32'd0);

        // Randomized traffic: latency 1..3, random stall/redirect/reset
        run(400, 3, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
